fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipelined RV32I core. Tracks writers in flight

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_match.sv | 31 +++
 rtl/fwd_hazard_unit.sv | 94 +++++++++
 tb/tb_fwd_hazard_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: in-flight writer slot, x0 constant and operand-select width helper.
// Used by the forwarding unit and the datapath pipeline registers.
package pipe_pkg;

  localparam logic [4:0] X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwren;
    logic       is_load;
  } slot_t;

  // Select code 0 means register file, k+1 means slot k.
  function automatic int sel_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search of the in-flight slots for one source register; youngest match wins.
// Purely combinational; reports whether the winning writer's result is available yet.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int NSTAGES         = 3,
  parameter int LOAD_READY_SLOT = 1,
  parameter int SELW            = sel_width(NSTAGES)
) (
  input  slot_t            slots [NSTAGES],
  input  logic [4:0]       rs,
  output logic             hit,
  output logic             ready,
  output logic [SELW-1:0]  sel
);

  // Scan oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].regwren && (slots[k].rd == rs) && (rs != X0)) begin
        hit   = 1'b1;
        ready = !slots[k].is_load || (k >= LOAD_READY_SLOT);
        sel   = SELW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall for the RV32I pipeline; stall is combinational, no added latency.
// A stall holds decode and bubbles slot 0; flush always bubbles slot 0 and wins over stall.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter  int DWIDTH          = 32,
  parameter  int NSTAGES         = 3,
  parameter  int LOAD_READY_SLOT = 1,
  parameter  int CNTW            = 32,
  localparam int SELW            = sel_width(NSTAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid_i,
  input  logic [4:0]                issue_rd_i,
  input  logic                      issue_regwren_i,
  input  logic                      issue_is_load_i,
  input  logic [4:0]                rs1_i,
  input  logic [4:0]                rs2_i,
  input  logic                      rs1_used_i,
  input  logic                      rs2_used_i,
  input  logic [DWIDTH-1:0]         rs1_rf_i,
  input  logic [DWIDTH-1:0]         rs2_rf_i,
  input  logic [NSTAGES*DWIDTH-1:0] stage_data_i,
  input  logic                      flush_i,
  output logic [DWIDTH-1:0]         rs1_data_o,
  output logic [DWIDTH-1:0]         rs2_data_o,
  output logic [SELW-1:0]           rs1_sel_o,
  output logic [SELW-1:0]           rs2_sel_o,
  output logic                      stall_o,
  output logic [CNTW-1:0]           stall_cycles_o
);

  slot_t           slots [NSTAGES];
  logic            rs1_hit, rs1_ready, rs2_hit, rs2_ready;
  logic [SELW-1:0] rs1_win, rs2_win;

  fwd_match #(.NSTAGES(NSTAGES), .LOAD_READY_SLOT(LOAD_READY_SLOT), .SELW(SELW)) u_match_rs1 (
    .slots (slots),
    .rs    (rs1_i),
    .hit   (rs1_hit),
    .ready (rs1_ready),
    .sel   (rs1_win)
  );

  fwd_match #(.NSTAGES(NSTAGES), .LOAD_READY_SLOT(LOAD_READY_SLOT), .SELW(SELW)) u_match_rs2 (
    .slots (slots),
    .rs    (rs2_i),
    .hit   (rs2_hit),
    .ready (rs2_ready),
    .sel   (rs2_win)
  );

  function automatic logic [DWIDTH-1:0] slot_result(input logic [SELW-1:0] s,
                                                    input logic [DWIDTH-1:0] rf);
    logic [DWIDTH-1:0] r;
    r = rf;
    for (int k = 0; k < NSTAGES; k++) begin
      if (s == SELW'(k + 1)) r = stage_data_i[k*DWIDTH +: DWIDTH];
    end
    return r;
  endfunction

  always_comb begin
    rs1_sel_o = (rs1_hit && rs1_ready) ? rs1_win : '0;
    rs2_sel_o = (rs2_hit && rs2_ready) ? rs2_win : '0;
    rs1_data_o = slot_result(rs1_sel_o, rs1_rf_i);
    rs2_data_o = slot_result(rs2_sel_o, rs2_rf_i);
    stall_o = (rs1_hit && !rs1_ready && rs1_used_i) || (rs2_hit && !rs2_ready && rs2_used_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTAGES; k++) slots[k] <= '0;
    end else begin
      for (int k = 1; k < NSTAGES; k++) slots[k] <= slots[k-1];
      if (issue_valid_i && !stall_o && !flush_i) begin
        slots[0] <= '{valid: 1'b1, rd: issue_rd_i, regwren: issue_regwren_i,
                      is_load: issue_is_load_i};
      end else begin
        slots[0] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_o <= '0;
    end else if (stall_o && (stall_cycles_o != {CNTW{1'b1}})) begin
      stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with an in-bench pipeline model checked every cycle.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_regwren, issue_is_load, flush;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_rf, rs2_rf;
  logic [95:0] stage_data;

  logic [31:0] rs1_data, rs2_data, stall_cycles;
  logic [1:0]  rs1_sel, rs2_sel;
  logic        stall;

  logic [31:0] s_rs1_data, s_rs2_data;
  logic [1:0]  s_rs1_sel, s_rs2_sel, s_stall_cycles;
  logic        s_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DWIDTH(32), .NSTAGES(3), .LOAD_READY_SLOT(1), .CNTW(32)) dut (
    .clk(clk), .reset(reset), .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .issue_regwren_i(issue_regwren), .issue_is_load_i(issue_is_load),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .rs1_rf_i(rs1_rf), .rs2_rf_i(rs2_rf), .stage_data_i(stage_data), .flush_i(flush),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .rs1_sel_o(rs1_sel), .rs2_sel_o(rs2_sel),
    .stall_o(stall), .stall_cycles_o(stall_cycles)
  );

  fwd_hazard_unit #(.DWIDTH(32), .NSTAGES(3), .LOAD_READY_SLOT(1), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .issue_regwren_i(issue_regwren), .issue_is_load_i(issue_is_load),
    .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .rs1_rf_i(rs1_rf), .rs2_rf_i(rs2_rf), .stage_data_i(stage_data), .flush_i(flush),
    .rs1_data_o(s_rs1_data), .rs2_data_o(s_rs2_data), .rs1_sel_o(s_rs1_sel),
    .rs2_sel_o(s_rs2_sel), .stall_o(s_stall), .stall_cycles_o(s_stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of writers issued in each of the last three cycles, youngest first.
  logic       m_v [3];
  logic [4:0] m_rd [3];
  logic       m_wr [3];
  logic       m_ld [3];
  int         m_cnt;
  bit         model_ok = 0;

  function automatic void model_eval(input logic [4:0] rs, input logic used,
                                     input logic [31:0] rf, output logic [1:0] sel,
                                     output logic [31:0] data, output logic haz);
    bit found;
    sel = 0; data = rf; haz = 0; found = 0;
    for (int k = 0; k < 3; k++) begin
      if (!found && m_v[k] && m_wr[k] && m_rd[k] == rs && rs != 0) begin
        found = 1;
        if (!m_ld[k] || k >= 1) begin
          sel = 2'(k + 1);
          data = stage_data[k*32 +: 32];
        end else if (used) begin
          haz = 1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    logic [1:0] s1, s2;
    logic [31:0] d1, d2;
    logic h1, h2;
    if (reset) begin
      for (int k = 0; k < 3; k++) m_v[k] = 0;
      m_cnt = 0;
      model_ok = 1;
    end else if (model_ok) begin
      model_eval(rs1, rs1_used, rs1_rf, s1, d1, h1);
      model_eval(rs2, rs2_used, rs2_rf, s2, d2, h2);
      for (int k = 2; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[0] = issue_valid && !(h1 || h2) && !flush;
      m_rd[0] = issue_rd; m_wr[0] = issue_regwren; m_ld[0] = issue_is_load;
      if (h1 || h2) m_cnt++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] s1, s2;
    logic [31:0] d1, d2;
    logic h1, h2;
    if (model_ok) begin
      model_eval(rs1, rs1_used, rs1_rf, s1, d1, h1);
      model_eval(rs2, rs2_used, rs2_rf, s2, d2, h2);
      chk("m_stall", 32'(stall), 32'(h1 || h2));
      chk("m_rs1_sel", 32'(rs1_sel), 32'(s1));
      chk("m_rs2_sel", 32'(rs2_sel), 32'(s2));
      if (!h1) chk("m_rs1_data", rs1_data, d1);
      if (!h2) chk("m_rs2_data", rs2_data, d2);
      chk("m_cnt", stall_cycles, 32'(m_cnt));
      chk("m_sat_cnt", 32'(s_stall_cycles), 32'(m_cnt > 3 ? 3 : m_cnt));
      chk("m_sat_stall", 32'(s_stall), 32'(h1 || h2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_regwren = 0; issue_is_load = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld);
    issue_valid = 1; issue_rd = rd; issue_regwren = 1; issue_is_load = ld;
  endtask

  initial begin
    reset = 1;
    idle();
    rs1_rf = 32'h0000_1111;
    rs2_rf = 32'h0000_2222;
    stage_data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hDEAD_BEEF};
    step(); step();
    reset = 0;
    rs1 = 5; rs1_used = 1;
    #2;
    chk("reset_stall", 32'(stall), 0);
    chk("reset_sel", 32'(rs1_sel), 0);
    chk("reset_data", rs1_data, 32'h0000_1111);
    chk("reset_cnt", stall_cycles, 0);

    // ALU -> ALU forward from slot 0
    idle(); issue(5, 0); step();
    idle(); rs1 = 5; rs1_used = 1; #2;
    chk("alu_sel", 32'(rs1_sel), 1);
    chk("alu_data", rs1_data, 32'hDEAD_BEEF);
    chk("alu_stall", 32'(stall), 0);
    step();

    // Load-use: one stall cycle, then forward from slot 1
    idle(); issue(7, 1); step();
    idle(); issue(8, 0); rs2 = 7; rs2_used = 1; #2;
    chk("lu_stall", 32'(stall), 1);
    step();
    chk("lu_stall_gone", 32'(stall), 0);
    chk("lu_sel", 32'(rs2_sel), 2);
    chk("lu_data", rs2_data, 32'hBBBB_0001);
    chk("lu_cnt", stall_cycles, 1);
    step();

    // Unused source never stalls
    idle(); issue(7, 1); step();
    idle(); rs2 = 7; rs2_used = 0; #2;
    chk("unused_stall", 32'(stall), 0);
    chk("unused_sel", 32'(rs2_sel), 0);

    // Youngest of two rd=3 writers wins, both ports agree
    idle(); issue(3, 0); step();
    idle(); step();
    issue(3, 0); step();
    idle(); rs1 = 3; rs2 = 3; rs1_used = 1; rs2_used = 1; #2;
    chk("prio_sel1", 32'(rs1_sel), 1);
    chk("prio_sel2", 32'(rs2_sel), 1);
    chk("prio_data2", rs2_data, 32'hDEAD_BEEF);

    // x0 writer never matches
    idle(); issue(0, 0); step();
    idle(); rs1 = 0; rs1_used = 1; rs1_rf = 32'h0000_1234; #2;
    chk("x0_sel", 32'(rs1_sel), 0);
    chk("x0_data", rs1_data, 32'h0000_1234);

    // Flushed issue does not become a writer
    idle(); issue(9, 0); flush = 1; step();
    idle(); rs1 = 9; rs1_used = 1; #2;
    chk("flush_sel", 32'(rs1_sel), 0);

    // Flush during a stall still bubbles and still counts
    idle(); issue(10, 1); step();
    idle(); issue(11, 0); rs1 = 10; rs1_used = 1; flush = 1; #2;
    chk("fl_stall", 32'(stall), 1);
    step();
    chk("fl_cnt", stall_cycles, 2);
    chk("fl_nostall", 32'(stall), 0);

    // Reset with three writers in flight and a hazard pending
    idle(); issue(1, 0); step();
    issue(2, 0); step();
    issue(4, 1); step();
    idle(); rs1 = 4; rs1_used = 1; #2;
    chk("rst_pre_stall", 32'(stall), 1);
    reset = 1; step();
    reset = 0; rs2 = 2; rs2_used = 1; #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_sel1", 32'(rs1_sel), 0);
    chk("rst_sel2", 32'(rs2_sel), 0);
    chk("rst_cnt", stall_cycles, 0);

    // Four load-use stalls: wide counter reads 4, 2-bit counter pins at 3
    for (int i = 0; i < 4; i++) begin
      idle(); issue(6, 1); step();
      idle(); issue(12, 0); rs1 = 6; rs1_used = 1; step();
    end
    idle(); #2;
    chk("sat_wide", stall_cycles, 4);
    chk("sat_narrow", 32'(s_stall_cycles), 3);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
